// File: rtl/cpu_run_controller_pkg.sv
// Shared definitions for the accumulator-CPU run controller: host command
// opcodes, CTRL sub-codes, controller state encoding and halt-cause codes.
package cpu_ctrl_pkg;

  // Host command opcodes (cmd_op)
  localparam logic [1:0] OP_LOAD_ADDR = 2'b00;
  localparam logic [1:0] OP_WRITE     = 2'b01;
  localparam logic [1:0] OP_CTRL      = 2'b10;
  localparam logic [1:0] OP_SET_BKPT  = 2'b11;

  // CTRL sub-codes carried in cmd_data[1:0]
  localparam logic [1:0] CTRL_HALT     = 2'b00;
  localparam logic [1:0] CTRL_RUN      = 2'b01;
  localparam logic [1:0] CTRL_STEP     = 2'b10;
  localparam logic [1:0] CTRL_CORE_RST = 2'b11;

  // Reasons the controller last entered HALT
  localparam logic [1:0] CAUSE_RESET = 2'b00;
  localparam logic [1:0] CAUSE_HOST  = 2'b01;
  localparam logic [1:0] CAUSE_BKPT  = 2'b10;
  localparam logic [1:0] CAUSE_STEP  = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    ST_HALT     = 2'b00,
    ST_RUN      = 2'b01,
    ST_STEP     = 2'b10,
    ST_CORE_RST = 2'b11
  } state_t;

  // True when a command op may be accepted in the given state
  function automatic logic op_accepted_in(input state_t st, input logic [1:0] op);
    logic ok;
    ok = 1'b0;
    case (st)
      ST_HALT: ok = 1'b1;
      ST_RUN:  ok = (op == OP_CTRL);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/cpu_run_controller_if.sv
// Host command channel plus the instruction-memory write port. The host
// side (master) issues commands; the controller (slave) answers with
// cmd_ready and produces the registered memory write strobe.
interface cpu_run_controller_if #(
  parameter int ADDR_W = 8
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [7:0]        cmd_data;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready,
    input  mem_we,
    input  mem_waddr,
    input  mem_wdata
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready,
    output mem_we,
    output mem_waddr,
    output mem_wdata
  );

endinterface

// File: rtl/cpu_run_controller.sv
// Host-facing run controller for the 8-bit accumulator core: loads program
// bytes, gates the core clock-enable, pulses the core reset, and implements
// halt / run / single-step with one PC breakpoint and a retired counter.
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int RST_CYCLES = 4,
  parameter int INSTRET_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cpu_run_controller_if.slave  bus,
  input  logic [ADDR_W-1:0]    core_pc,
  output logic                 core_en,
  output logic                 core_rst_n,
  output logic                 halted,
  output logic [1:0]           halt_cause,
  output logic [INSTRET_W-1:0] instret
);

  // Width of the core-reset timer; it counts RST_CYCLES-1 down to 0
  localparam int RST_CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_CNT_W-1:0] RST_LOAD = RST_CNT_W'(RST_CYCLES - 1);

  state_t                 state;
  state_t                 state_next;
  logic [1:0]             cause;
  logic [1:0]             cause_next;
  logic                   rst_cnt_load;
  logic [RST_CNT_W-1:0]   rst_cnt;
  logic [ADDR_W-1:0]      wptr;
  logic [ADDR_W-1:0]      bkpt_pc;
  logic                   bkpt_en;
  logic [INSTRET_W-1:0]   instret_q;
  logic                   accept;
  logic                   ctrl_cmd;
  logic [1:0]             ctrl_code;
  logic                   bkpt_hit;
  logic                   core_rst_done;

  // Command handshake and decoded control terms
  always_comb begin
    bus.cmd_ready = op_accepted_in(state, bus.cmd_op);
    accept        = bus.cmd_valid & bus.cmd_ready;
    ctrl_cmd      = accept & (bus.cmd_op == OP_CTRL);
    ctrl_code     = bus.cmd_data[1:0];
    bkpt_hit      = bkpt_en & (core_pc == bkpt_pc) & (state == ST_RUN);
    core_rst_done = (state == ST_CORE_RST) && (rst_cnt == '0);
  end

  // Core-facing outputs; the breakpoint gates core_en in the same cycle
  always_comb begin
    core_en    = ((state == ST_RUN) & ~bkpt_hit) |
                 (state == ST_STEP) |
                 (state == ST_CORE_RST);
    core_rst_n = (state != ST_CORE_RST);
    halted     = (state == ST_HALT);
    halt_cause = cause;
    instret    = instret_q;
  end

  // Next-state and halt-cause selection
  always_comb begin
    state_next   = state;
    cause_next   = cause;
    rst_cnt_load = 1'b0;
    case (state)
      ST_HALT: begin
        if (ctrl_cmd) begin
          case (ctrl_code)
            CTRL_HALT:     cause_next = CAUSE_HOST;
            CTRL_RUN:      state_next = ST_RUN;
            CTRL_STEP:     state_next = ST_STEP;
            CTRL_CORE_RST: begin
              state_next   = ST_CORE_RST;
              rst_cnt_load = 1'b1;
            end
            default:       state_next = ST_HALT;
          endcase
        end
      end
      ST_RUN: begin
        if (ctrl_cmd && (ctrl_code == CTRL_CORE_RST)) begin
          state_next   = ST_CORE_RST;
          rst_cnt_load = 1'b1;
        end else if (ctrl_cmd && ((ctrl_code == CTRL_HALT) || (ctrl_code == CTRL_STEP))) begin
          state_next = ST_HALT;
          cause_next = CAUSE_HOST;
        end else if (bkpt_hit) begin
          state_next = ST_HALT;
          cause_next = CAUSE_BKPT;
        end
      end
      ST_STEP: begin
        state_next = ST_HALT;
        cause_next = CAUSE_STEP;
      end
      ST_CORE_RST: begin
        if (core_rst_done) begin
          state_next = ST_HALT;
          cause_next = CAUSE_RESET;
        end
      end
      default: begin
        state_next = ST_HALT;
        cause_next = CAUSE_RESET;
      end
    endcase
  end

  // State and halt-cause registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_HALT;
      cause <= CAUSE_RESET;
    end else begin
      state <= state_next;
      cause <= cause_next;
    end
  end

  // Core-reset timer: loaded on entry, counts down while the core is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt <= '0;
    end else if (rst_cnt_load) begin
      rst_cnt <= RST_LOAD;
    end else if ((state == ST_CORE_RST) && (rst_cnt != '0)) begin
      rst_cnt <= rst_cnt - 1'b1;
    end
  end

  // Program-load path: registered write strobe and auto-incrementing pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_we    <= 1'b0;
      bus.mem_waddr <= '0;
      bus.mem_wdata <= '0;
      wptr          <= '0;
    end else begin
      bus.mem_we <= accept & (bus.cmd_op == OP_WRITE);
      if (accept && (bus.cmd_op == OP_WRITE)) begin
        bus.mem_waddr <= wptr;
        bus.mem_wdata <= bus.cmd_data;
        wptr          <= wptr + 1'b1;
      end else if (accept && (bus.cmd_op == OP_LOAD_ADDR)) begin
        wptr <= ADDR_W'(bus.cmd_data);
      end
    end
  end

  // Breakpoint register: armed by SET_BKPT, only cleared by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bkpt_pc <= '0;
      bkpt_en <= 1'b0;
    end else if (accept && (bus.cmd_op == OP_SET_BKPT)) begin
      bkpt_pc <= ADDR_W'(bus.cmd_data);
      bkpt_en <= 1'b1;
    end
  end

  // Retired-instruction counter: saturating, cleared when a core reset ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (core_rst_done) begin
      instret_q <= '0;
    end else if (core_en && core_rst_n && (instret_q != '1)) begin
      instret_q <= instret_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: directed scenarios followed by random
// command sequences checked against a transaction-level model of the
// controller and a simple incrementing-PC core.
module tb_cpu_run_controller;
  import cpu_ctrl_pkg::*;

  // A narrow counter lets saturation be reached within a short run
  localparam int INSTRET_W   = 4;
  localparam int INSTRET_MAX = (1 << INSTRET_W) - 1;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [7:0]           core_pc = 8'h00;
  logic                 core_en;
  logic                 core_rst_n;
  logic                 halted;
  logic [1:0]           halt_cause;
  logic [INSTRET_W-1:0] instret;
  int                   cycle = 0;
  int                   checks = 0;
  int                   errors = 0;
  wr_t                  obs_q[$];
  wr_t                  exp_q[$];

  int m_wptr, m_pc, m_instret, m_bkpt;
  bit m_armed;

  cpu_run_controller_if #(.ADDR_W(8)) bus ();

  cpu_run_controller #(
    .ADDR_W(8),
    .RST_CYCLES(4),
    .INSTRET_W(INSTRET_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .core_pc(core_pc),
    .core_en(core_en),
    .core_rst_n(core_rst_n),
    .halted(halted),
    .halt_cause(halt_cause),
    .instret(instret)
  );

  // Clock generation
  always #5 clk = ~clk;

  // Cycle counter used to timestamp memory writes
  always @(posedge clk) cycle <= cycle + 1;

  // Minimal core: PC advances when enabled, synchronous reset to 0
  always @(posedge clk) begin
    if (!core_rst_n) core_pc <= 8'h00;
    else if (core_en) core_pc <= core_pc + 8'h01;
  end

  // Record every instruction-memory write seen on the port
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1)
      obs_q.push_back('{addr: bus.mem_waddr, data: bus.mem_wdata, cyc: cycle});
  end

  // Run-away guard
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > INSTRET_MAX) ? INSTRET_MAX : a + b;
  endfunction

  // Present a command at the next falling edge and hold it until accepted
  task automatic send_cmd(input logic [1:0] op, input logic [7:0] data);
    int waits;
    waits = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    #1;
    while (bus.cmd_ready !== 1'b1 && waits < 64) begin
      @(negedge clk);
      #1;
      waits++;
    end
    check_output("cmd_accept_timeout", 32'(waits < 64), 32'd1);
    if (waits < 64) @(posedge clk);
    else bus.cmd_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_halted(input string tag);
    int n;
    n = 0;
    idle_cycles(1);
    #1;
    while (halted !== 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_output({tag, "_halt_timeout"}, 32'(n < 40), 32'd1);
  endtask

  task automatic model_write(input logic [7:0] data);
    exp_q.push_back('{addr: 8'(m_wptr), data: data, cyc: 0});
    m_wptr = (m_wptr + 1) & 255;
  endtask

  task automatic compare_writes(input string tag);
    wr_t o, e;
    check_output({tag, "_wr_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check_output({tag, "_wr_addr"}, 32'(o.addr), 32'(e.addr));
      check_output({tag, "_wr_data"}, 32'(o.data), 32'(e.data));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // Directed scenarios, then randomized command sequences
  initial begin
    int         cnt;
    int         w;
    int         d;
    int         exec;
    bit         exp_h;
    logic [7:0] rnd;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_LOAD_ADDR;
    bus.cmd_data  = 8'h00;
    m_wptr = 0; m_pc = 0; m_instret = 0; m_bkpt = 0; m_armed = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1. Reset in the middle of a WRITE burst
    send_cmd(OP_WRITE, 8'h11);
    send_cmd(OP_WRITE, 8'h22);
    @(negedge clk);
    #1;
    check_output("t1_we_before_rst", 32'(bus.mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("t1_we_in_rst", 32'(bus.mem_we), 32'd0);
    check_output("t1_core_en_in_rst", 32'(core_en), 32'd0);
    check_output("t1_core_rst_n_in_rst", 32'(core_rst_n), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check_output("t1_halted", 32'(halted), 32'd1);
    check_output("t1_cause", 32'(halt_cause), 32'(CAUSE_RESET));
    check_output("t1_instret", 32'(instret), 32'd0);
    check_output("t1_ready", 32'(bus.cmd_ready), 32'd1);
    obs_q.delete();
    m_wptr = 0;

    // 2. Program load wrapping across the top of memory
    send_cmd(OP_LOAD_ADDR, 8'hFE);
    m_wptr = 8'hFE;
    send_cmd(OP_WRITE, 8'h21); model_write(8'h21);
    send_cmd(OP_WRITE, 8'h13); model_write(8'h13);
    send_cmd(OP_WRITE, 8'h34); model_write(8'h34);
    send_cmd(OP_WRITE, 8'h55); model_write(8'h55);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    #1;
    check_output("t2_we_latency", 32'(bus.mem_we), 32'd1);
    check_output("t2_last_addr", 32'(bus.mem_waddr), 32'h01);
    @(negedge clk);
    #1;
    check_output("t2_we_single", 32'(bus.mem_we), 32'd0);
    if (obs_q.size() >= 4)
      for (int i = 1; i < 4; i++)
        check_output("t2_wr_spacing", 32'(obs_q[i].cyc - obs_q[i-1].cyc), 32'd1);
    compare_writes("t2");

    // 3. Breakpoint stops the core before executing bkpt_pc
    send_cmd(OP_SET_BKPT, 8'h0A);
    m_bkpt = 8'h0A; m_armed = 1;
    send_cmd(OP_CTRL, {6'd0, CTRL_RUN});
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      #1;
      if (halted === 1'b1) break;
      if (core_pc == 8'h0A) check_output("t3_en_at_bkpt", 32'(core_en), 32'd0);
      if (core_en === 1'b1) cnt++;
    end
    exec = (m_bkpt - m_pc) & 255;
    check_output("t3_en_cycles", 32'(cnt), 32'(exec));
    m_pc = m_bkpt; m_instret = sat_add(m_instret, exec);
    check_output("t3_halted", 32'(halted), 32'd1);
    check_output("t3_cause", 32'(halt_cause), 32'(CAUSE_BKPT));
    check_output("t3_instret", 32'(instret), 32'(m_instret));
    check_output("t3_pc", 32'(core_pc), 32'(m_pc));

    // 4. Single step off the breakpoint
    send_cmd(OP_CTRL, {6'd0, CTRL_STEP});
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    #1;
    check_output("t4_en_step", 32'(core_en), 32'd1);
    @(negedge clk);
    #1;
    m_pc = (m_pc + 1) & 255; m_instret = sat_add(m_instret, 1);
    check_output("t4_en_after", 32'(core_en), 32'd0);
    check_output("t4_cause", 32'(halt_cause), 32'(CAUSE_STEP));
    check_output("t4_instret", 32'(instret), 32'(m_instret));
    check_output("t4_pc", 32'(core_pc), 32'h0B);

    // 5. Non-CTRL commands stall while running
    send_cmd(OP_CTRL, {6'd0, CTRL_RUN});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_WRITE;
      bus.cmd_data  = 8'h77;
      #1;
      check_output("t5_stall_ready", 32'(bus.cmd_ready), 32'd0);
    end
    send_cmd(OP_CTRL, {6'd0, CTRL_HALT});
    m_pc = (m_pc + 6) & 255; m_instret = sat_add(m_instret, 6);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_WRITE;
    bus.cmd_data  = 8'h77;
    #1;
    check_output("t5_halted", 32'(halted), 32'd1);
    check_output("t5_ready_after_halt", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    model_write(8'h77);
    idle_cycles(2);
    #1;
    check_output("t5_cause", 32'(halt_cause), 32'(CAUSE_HOST));
    check_output("t5_instret_sat", 32'(instret), 32'(m_instret));
    check_output("t5_pc", 32'(core_pc), 32'(m_pc));
    compare_writes("t5");

    // 6. Core reset pulse length and command blocking
    send_cmd(OP_CTRL, {6'd0, CTRL_CORE_RST});
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_CTRL;
      #1;
      if (core_rst_n === 1'b0) begin
        cnt++;
        check_output("t6_ready_low", 32'(bus.cmd_ready), 32'd0);
      end else begin
        break;
      end
    end
    m_pc = 0; m_instret = 0;
    check_output("t6_rst_cycles", 32'(cnt), 32'd4);
    check_output("t6_halted", 32'(halted), 32'd1);
    check_output("t6_cause", 32'(halt_cause), 32'(CAUSE_RESET));
    check_output("t6_instret", 32'(instret), 32'd0);
    check_output("t6_pc", 32'(core_pc), 32'd0);

    // Randomized command sequences against the model
    for (int it = 0; it < 60; it++) begin
      rnd = 8'($urandom);
      case ($urandom_range(0, 6))
        0: begin
          send_cmd(OP_LOAD_ADDR, rnd);
          m_wptr = rnd;
        end
        1: begin
          send_cmd(OP_WRITE, rnd);
          model_write(rnd);
        end
        2: begin
          if ($urandom_range(0, 1) == 1) rnd = 8'(m_pc + $urandom_range(0, 12));
          send_cmd(OP_SET_BKPT, rnd);
          m_bkpt = rnd; m_armed = 1;
        end
        3: begin
          send_cmd(OP_CTRL, {rnd[7:2], CTRL_STEP});
          idle_cycles(2);
          #1;
          check_output("r_step_cause", 32'(halt_cause), 32'(CAUSE_STEP));
          m_pc = (m_pc + 1) & 255; m_instret = sat_add(m_instret, 1);
        end
        4: begin
          w = $urandom_range(1, 12);
          send_cmd(OP_CTRL, {rnd[7:2], CTRL_RUN});
          idle_cycles(w);
          #1;
          d = (m_bkpt - m_pc) & 255;
          exp_h = m_armed && (d <= w - 2);
          check_output("r_run_bkpt_halted", 32'(halted), 32'(exp_h));
          if (exp_h) check_output("r_run_bkpt_cause", 32'(halt_cause), 32'(CAUSE_BKPT));
          send_cmd(OP_CTRL, {rnd[7:2], CTRL_HALT});
          idle_cycles(1);
          #1;
          check_output("r_run_host_cause", 32'(halt_cause), 32'(CAUSE_HOST));
          exec = (m_armed && d < w + 1) ? d : w + 1;
          m_pc = (m_pc + exec) & 255; m_instret = sat_add(m_instret, exec);
        end
        5: begin
          send_cmd(OP_CTRL, {rnd[7:2], CTRL_CORE_RST});
          wait_halted("r_core_rst");
          check_output("r_core_rst_cause", 32'(halt_cause), 32'(CAUSE_RESET));
          m_pc = 0; m_instret = 0;
        end
        default: begin
          send_cmd(OP_CTRL, {rnd[7:2], CTRL_HALT});
          idle_cycles(1);
          #1;
          check_output("r_halt_cause", 32'(halt_cause), 32'(CAUSE_HOST));
        end
      endcase
      idle_cycles(2);
      #1;
      check_output("r_halted", 32'(halted), 32'd1);
      check_output("r_pc", 32'(core_pc), 32'(m_pc));
      check_output("r_instret", 32'(instret), 32'(m_instret));
    end
    compare_writes("r");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
